// File: rtl/kv_lzc_normalize_pkg.sv
// Shared definitions for the LZC normalizer: legal mantissa widths, the
// shift-count width derivation and the coarse/fine split of the shift.
package kv_lzc_normalize_pkg;

  localparam int unsigned KV_DEF_WIDTH      = 32;
  localparam int unsigned KV_DEF_EXP_WIDTH  = 10;

  // The fine shifter handles the low two count bits; the coarse shifter
  // handles the rest in steps of four.
  localparam int unsigned FINE_SHAMT_WIDTH  = 2;

  // Mantissa widths the FPU datapath is built for.
  function automatic bit kv_width_legal(input int unsigned w);
    return (w == 8) || (w == 32) || (w == 64) || (w == 128);
  endfunction

  // Width of a leading-zero count for a mantissa of w bits. The LZC encoder
  // uses the same function so the count widths always agree.
  function automatic int unsigned kv_encode_width(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/kv_lzc_normalize_if.sv
// Handshake and data bundle between the adder/LZC stage, the normalizer and
// the rounding stage.
interface kv_lzc_normalize_if
  import kv_lzc_normalize_pkg::*;
#(
  parameter int unsigned WIDTH     = KV_DEF_WIDTH,
  parameter int unsigned EXP_WIDTH = KV_DEF_EXP_WIDTH
) ();

  localparam int unsigned ENCODE_WIDTH = kv_encode_width(WIDTH);

  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_mant;
  logic [EXP_WIDTH-1:0]    in_exp;
  logic [ENCODE_WIDTH-1:0] in_lzc;

  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_mant;
  logic [EXP_WIDTH-1:0]    out_exp;
  logic                    out_adj;
  logic                    out_zero;

  // Upstream/downstream side that feeds operands and consumes results.
  modport master (
    output in_valid, in_mant, in_exp, in_lzc, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_adj, out_zero
  );

  // Normalizer side.
  modport slave (
    input  in_valid, in_mant, in_exp, in_lzc, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_adj, out_zero
  );

endinterface

// File: rtl/kv_lshift_stage.sv
// Combinational barrel-shift slice: shifts data_i left by
// shamt_i * 2**SHAMT_LSB, one mux level per shift-count bit.
module kv_lshift_stage #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SHAMT_WIDTH = 3,
  parameter int unsigned SHAMT_LSB   = 2
) (
  input  logic [WIDTH-1:0]       data_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic [WIDTH-1:0]       data_o
);

  // One conditional power-of-two shift per count bit.
  always_comb begin
    data_o = data_i;
    for (int k = 0; k < int'(SHAMT_WIDTH); k++) begin
      if (shamt_i[k]) begin
        data_o = data_o << (1 << (k + int'(SHAMT_LSB)));
      end
    end
  end

endmodule

// File: rtl/kv_lzc_normalize.sv
// Two-stage left normalizer: coarse shift by the anticipated count in S1,
// fine shift plus one-bit LZA correction and exponent adjust in S2.
module kv_lzc_normalize
  import kv_lzc_normalize_pkg::*;
#(
  parameter int unsigned WIDTH     = KV_DEF_WIDTH,
  parameter int unsigned EXP_WIDTH = KV_DEF_EXP_WIDTH
) (
  input  logic               core_clk,
  input  logic               core_reset,
  kv_lzc_normalize_if.slave  bus
);

  localparam int unsigned ENCODE_WIDTH = kv_encode_width(WIDTH);
  localparam int unsigned COARSE_WIDTH = ENCODE_WIDTH - FINE_SHAMT_WIDTH;

  if (!kv_width_legal(WIDTH)) begin : g_bad_width
    $error("kv_lzc_normalize: WIDTH %0d is not one of 8, 32, 64, 128", WIDTH);
  end

  logic                        s1_valid_q;
  logic [WIDTH-1:0]            s1_mant_q;
  logic [FINE_SHAMT_WIDTH-1:0] s1_fine_q;
  logic [EXP_WIDTH-1:0]        s1_exp_q;
  logic                        s1_zero_q;

  logic [WIDTH-1:0]            s1_mant_d;
  logic [EXP_WIDTH-1:0]        s1_exp_d;
  logic                        s1_zero_d;

  logic                        s2_valid_q;
  logic [WIDTH-1:0]            s2_mant_q;
  logic [EXP_WIDTH-1:0]        s2_exp_q;
  logic                        s2_adj_q;
  logic                        s2_zero_q;

  logic [WIDTH-1:0]            s2_mant_d;
  logic [EXP_WIDTH-1:0]        s2_exp_d;
  logic                        s2_adj_d;
  logic [WIDTH-1:0]            fine_mant;

  logic                        s1_adv;
  logic                        s2_adv;

  // A stage may load when it is empty or its contents move on this edge.
  assign s2_adv       = ~s2_valid_q | bus.out_ready;
  assign s1_adv       = ~s1_valid_q | s2_adv;
  assign bus.in_ready = s1_adv;

  kv_lshift_stage #(
    .WIDTH       (WIDTH),
    .SHAMT_WIDTH (COARSE_WIDTH),
    .SHAMT_LSB   (FINE_SHAMT_WIDTH)
  ) u_coarse (
    .data_i  (bus.in_mant),
    .shamt_i (bus.in_lzc[ENCODE_WIDTH-1:FINE_SHAMT_WIDTH]),
    .data_o  (s1_mant_d)
  );

  assign s1_exp_d  = bus.in_exp - EXP_WIDTH'(bus.in_lzc);
  assign s1_zero_d = ~|bus.in_mant;

  kv_lshift_stage #(
    .WIDTH       (WIDTH),
    .SHAMT_WIDTH (FINE_SHAMT_WIDTH),
    .SHAMT_LSB   (0)
  ) u_fine (
    .data_i  (s1_mant_q),
    .shamt_i (s1_fine_q),
    .data_o  (fine_mant)
  );

  // Correction: an under-anticipated count leaves the MSB clear, so shift
  // one more place and take one more off the exponent. Zero forces all-zero.
  always_comb begin
    s2_mant_d = fine_mant;
    s2_exp_d  = s1_exp_q;
    s2_adj_d  = 1'b0;
    if (s1_zero_q) begin
      s2_mant_d = '0;
      s2_exp_d  = '0;
    end else if (!fine_mant[WIDTH-1]) begin
      s2_mant_d = fine_mant << 1;
      s2_exp_d  = s1_exp_q - EXP_WIDTH'(1);
      s2_adj_d  = 1'b1;
    end
  end

  // S1 register: captures an accepted beat, holds while stalled.
  always_ff @(posedge core_clk) begin
    if (core_reset) begin
      s1_valid_q <= 1'b0;
      s1_mant_q  <= '0;
      s1_fine_q  <= '0;
      s1_exp_q   <= '0;
      s1_zero_q  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_mant_q <= s1_mant_d;
        s1_fine_q <= bus.in_lzc[FINE_SHAMT_WIDTH-1:0];
        s1_exp_q  <= s1_exp_d;
        s1_zero_q <= s1_zero_d;
      end
    end
  end

  // S2 register: drives the outputs directly, holds while stalled.
  always_ff @(posedge core_clk) begin
    if (core_reset) begin
      s2_valid_q <= 1'b0;
      s2_mant_q  <= '0;
      s2_exp_q   <= '0;
      s2_adj_q   <= 1'b0;
      s2_zero_q  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_mant_q <= s2_mant_d;
        s2_exp_q  <= s2_exp_d;
        s2_adj_q  <= s2_adj_d;
        s2_zero_q <= s1_zero_q;
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_mant  = s2_mant_q;
  assign bus.out_exp   = s2_exp_q;
  assign bus.out_adj   = s2_adj_q;
  assign bus.out_zero  = s2_zero_q;

endmodule
